// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing for 800x600 / 1024x768 / 1280x720 with HS, VS, DE, fetch request and SOF.
// Latency: every output is registered one cycle behind the h/v counter state; O_req leads O_de by PREFETCH cycles.
// Backpressure: none, the raster free-runs while I_enable is high and parks at h=0,v=0 with idle outputs while low.
// Build option: define VTG_COORD_EN to include the O_x/O_y coordinate logic; otherwise both are tied to 0.
module video_timing_gen #(
  parameter int         CNT_W        = 12,
  parameter logic [1:0] DEFAULT_MODE = 2'd2,
  parameter int         PREFETCH     = 2,
  parameter bit         HS_POL       = 1'b1,
  parameter bit         VS_POL       = 1'b1
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst,
  input  logic             I_enable,
  input  logic [1:0]       I_mode,
  output logic             O_hs,
  output logic             O_vs,
  output logic             O_de,
  output logic             O_req,
  output logic [CNT_W-1:0] O_x,
  output logic [CNT_W-1:0] O_y,
  output logic             O_sof,
  output logic [1:0]       O_mode,
  output logic             O_mode_err
);

  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] h_res;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
    logic [CNT_W-1:0] v_res;
  } timing_t;

  // Mode 3 is never applied by the sampler; it falls back to the 720p table
  function automatic timing_t mode_timing(input logic [1:0] mode);
    timing_t t;
    case (mode)
      2'd0: t = '{h_total: CNT_W'(1056), h_sync: CNT_W'(128), h_bp: CNT_W'(88),  h_res: CNT_W'(800),
                  v_total: CNT_W'(628),  v_sync: CNT_W'(4),   v_bp: CNT_W'(23),  v_res: CNT_W'(600)};
      2'd1: t = '{h_total: CNT_W'(1344), h_sync: CNT_W'(136), h_bp: CNT_W'(160), h_res: CNT_W'(1024),
                  v_total: CNT_W'(806),  v_sync: CNT_W'(6),   v_bp: CNT_W'(29),  v_res: CNT_W'(768)};
      default: t = '{h_total: CNT_W'(1650), h_sync: CNT_W'(40), h_bp: CNT_W'(220), h_res: CNT_W'(1280),
                     v_total: CNT_W'(750),  v_sync: CNT_W'(5),  v_bp: CNT_W'(20),  v_res: CNT_W'(720)};
    endcase
    return t;
  endfunction

  logic [1:0]       r_mode;
  logic             r_mode_err;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic             r_req;
  logic             r_sof;

  timing_t          w_t;
  logic [CNT_W-1:0] w_h_start;
  logic [CNT_W-1:0] w_h_end;
  logic [CNT_W-1:0] w_v_start;
  logic [CNT_W-1:0] w_v_end;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame_end;
  logic             w_h_act;
  logic             w_v_act;
  logic [CNT_W:0]   w_h_ahead;
  logic             w_req_act;
  logic             w_de_act;
  logic             w_sof_act;

  assign w_t       = mode_timing(r_mode);
  assign w_h_start = w_t.h_sync + w_t.h_bp;
  assign w_h_end   = w_h_start + w_t.h_res;
  assign w_v_start = w_t.v_sync + w_t.v_bp;
  assign w_v_end   = w_v_start + w_t.v_res;

  assign w_h_last    = (r_h_cnt == w_t.h_total - CNT_W'(1));
  assign w_v_last    = (r_v_cnt == w_t.v_total - CNT_W'(1));
  assign w_frame_end = w_h_last && w_v_last;

  assign w_h_act  = (r_h_cnt >= w_h_start) && (r_h_cnt < w_h_end);
  assign w_v_act  = (r_v_cnt >= w_v_start) && (r_v_cnt < w_v_end);
  assign w_de_act = w_h_act && w_v_act;

  // The request window is the DE window evaluated PREFETCH pixels ahead on the same line;
  // the extra bit keeps the look-ahead from wrapping near the end of the counter range
  assign w_h_ahead = {1'b0, r_h_cnt} + (CNT_W+1)'(PREFETCH);
  assign w_req_act = w_v_act && (w_h_ahead >= {1'b0, w_h_start}) && (w_h_ahead < {1'b0, w_h_end});

  assign w_sof_act = (r_h_cnt == w_h_start) && (r_v_cnt == w_v_start);

  // Raster counters: park at the origin while disabled, otherwise walk the frame
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!I_enable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  // Mode is only sampled on the last pixel of a frame, independent of I_enable on that cycle
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      r_mode     <= DEFAULT_MODE;
      r_mode_err <= 1'b0;
    end else if (w_frame_end) begin
      if (I_mode == 2'd3) begin
        r_mode_err <= 1'b1;
      end else begin
        r_mode <= I_mode;
      end
    end
  end

  // Registered sync/enable outputs, forced idle while disabled
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_req <= 1'b0;
      r_sof <= 1'b0;
    end else if (!I_enable) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_req <= 1'b0;
      r_sof <= 1'b0;
    end else begin
      r_hs  <= (r_h_cnt < w_t.h_sync) ? HS_POL : ~HS_POL;
      r_vs  <= (r_v_cnt < w_t.v_sync) ? VS_POL : ~VS_POL;
      r_de  <= w_de_act;
      r_req <= w_req_act;
      r_sof <= w_sof_act;
    end
  end

`ifdef VTG_COORD_EN
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;

  // Coordinates relative to the first active pixel/line, zero outside the active window
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (I_enable && w_de_act) begin
      r_x <= r_h_cnt - w_h_start;
      r_y <= r_v_cnt - w_v_start;
    end else begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  assign O_x = r_x;
  assign O_y = r_y;
`else
  assign O_x = '0;
  assign O_y = '0;
`endif

  assign O_hs       = r_hs;
  assign O_vs       = r_vs;
  assign O_de       = r_de;
  assign O_req      = r_req;
  assign O_sof      = r_sof;
  assign O_mode     = r_mode;
  assign O_mode_err = r_mode_err;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 12: width of the horizontal/vertical counters and coordinate outputs.
REQ-002 SHALL have parameter DEFAULT_MODE, default 2: mode loaded at reset.
REQ-003 SHALL have parameter PREFETCH, default 2: lead of O_req over O_de in cycles, legal range 0..15.
REQ-004 SHALL have parameter HS_POL, default 1: HS active level.
REQ-005 SHALL have parameter VS_POL, default 1: VS active level.
REQ-006 SHALL have port I_pxl_clk  in  1  pixel clock; single clock domain.
REQ-007 SHALL have port I_rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port I_enable  in  1  run when high.
REQ-009 SHALL have port I_mode  in  2  requested mode: 0=800x600, 1=1024x768, 2=1280x720, 3=reserved.
REQ-010 SHALL have port O_hs  out  1  horizontal sync.
REQ-011 SHALL have port O_vs  out  1  vertical sync.
REQ-012 SHALL have port O_de  out  1  data enable.
REQ-013 SHALL have port O_req  out  1  pixel-fetch request, O_de advanced by PREFETCH cycles.
REQ-014 SHALL have port O_x  out  CNT_W  active-pixel column.
REQ-015 SHALL have port O_y  out  CNT_W  active-line row.
REQ-016 SHALL have port O_sof  out  1  one-cycle pulse with first active pixel of frame.
REQ-017 SHALL have port O_mode  out  2  currently applied mode.
REQ-018 SHALL have port O_mode_err  out  1  sticky: reserved mode requested.

Function
REQ-019 SHALL use these per-mode constants {h_total,h_sync,h_bp,h_res,v_total,v_sync,v_bp,v_res}: mode 0 {1056,128,88,800,628,4,23,600}; mode 1 {1344,136,160,1024,806,6,29,768}; mode 2 {1650,40,220,1280,750,5,20,720}.
REQ-020 SHALL run h_cnt from 0 to h_total-1, then wrap to 0 and increment v_cnt; v_cnt SHALL wrap to 0 after v_total-1.
REQ-021 SHALL drive O_hs active while h_cnt<h_sync, and O_vs active while v_cnt<v_sync, at the level set by HS_POL/VS_POL.
REQ-022 SHALL drive O_de while h_cnt is in [h_sync+h_bp, h_sync+h_bp+h_res) and v_cnt is in [v_sync+v_bp, v_sync+v_bp+v_res).
REQ-023 SHALL register all outputs, giving exactly 1 cycle of latency from the counter state, with O_hs, O_vs, O_de, O_x, O_y and O_sof mutually aligned.
REQ-024 SHALL assert O_req on the same lines as O_de, exactly PREFETCH cycles earlier, with identical width; PREFETCH=0 SHALL make O_req equal O_de.
REQ-025 SHALL output O_x = h_cnt-(h_sync+h_bp) and O_y = v_cnt-(v_sync+v_bp) while O_de is high, and 0 otherwise.
REQ-026 SHALL sample I_mode only on the cycle where h_cnt=h_total-1 and v_cnt=v_total-1; the new mode SHALL apply from the next cycle (h=0, v=0) and mid-frame changes SHALL be ignored.
REQ-027 SHALL, when sampling I_mode=3, keep the current mode and set O_mode_err, which SHALL clear only on reset.
REQ-028 SHALL, while I_enable is low, hold h_cnt=v_cnt=0 with O_de, O_req and O_sof low and O_hs/O_vs inactive; the rise of I_enable SHALL start a frame at h=0, v=0.
REQ-029 SHALL apply a mode sample at the frame boundary even when I_enable falls on that same cycle.

Reset
REQ-030 SHALL, on I_rst, immediately clear counters, O_de, O_req, O_sof, O_x, O_y and O_mode_err, set O_hs=~HS_POL and O_vs=~VS_POL, and load O_mode=DEFAULT_MODE.
REQ-031 SHALL resume on the first clock after I_rst deasserts at h=0, v=0, with no partial frame retained from before reset.

Configuration
REQ-032 SHALL include the O_x/O_y coordinate logic when VTG_COORD_EN is defined; when it is undefined, O_x and O_y SHALL be tied to 0 and the coordinate logic removed, with all other behaviour unchanged.

Verification
REQ-033 Bench SHALL check: mode 2, enable -> 750 lines of 1650 cycles; O_de high 1280 cycles/line for 720 lines; O_hs high 40 cycles.
REQ-034 Bench SHALL check: I_mode 2->0 at mid-frame -> O_mode stays 2 until the frame wraps, then 800x600 timing, with the first O_sof after 1056*(4+23)+128+88+1 cycles.
REQ-035 Bench SHALL check: PREFETCH=2 -> O_req rises 2 cycles before O_de on every active line, both 1280 wide.
REQ-036 Bench SHALL check: I_mode=3 at the boundary -> O_mode unchanged and O_mode_err=1 until I_rst.
REQ-037 Bench SHALL check: I_rst asserted at line 300 -> outputs inactive asynchronously; after release, O_sof occurs after 1650*25+260+1 cycles.
REQ-038 Bench SHALL check: VTG_COORD_EN set -> last active pixel shows O_x=1279, O_y=719; macro undefined -> O_x=O_y=0 throughout.
